// File: rtl/rv_elastic_reg_if.sv
// Handshake bundle for rv_elastic_reg: producer side, consumer side and occupancy status.
// slave is the view of the storage block itself; master is the view of whatever drives it.
interface rv_elastic_reg_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, full, empty
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, full, empty
  );
endinterface

// File: rtl/rv_elastic_reg.sv
// Valid/ready elastic buffer of DEPTH slots with FIFO ordering, no in-to-out bypass,
// asynchronous active-low reset and a synchronous flush that wins over push and pop.
module rv_elastic_reg #(
  parameter int               WIDTH       = 3,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  rv_elastic_reg_if.slave bus
);
  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] slot_q [DEPTH];
  logic             full, empty, push, pop;

  // Handshake qualifiers depend only on registered occupancy, so in_ready never sees out_ready.
  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = bus.out_ready && !empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (clr) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Slots are plain registers because both reset and flush must restore every one of them.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [WIDTH-1:0] data_reg;
      logic             wr_en;

      assign wr_en = push && (wr_ptr_reg == AW'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_reg <= RESET_VALUE;
        end else if (clr) begin
          data_reg <= RESET_VALUE;
        end else if (wr_en) begin
          data_reg <= bus.in_data;
        end
      end

      assign slot_q[gi] = data_reg;
    end
  endgenerate

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? RESET_VALUE : slot_q[rd_ptr_reg];
  assign bus.count     = count_reg;
  assign bus.full      = full;
  assign bus.empty     = empty;
endmodule

// File: tb/tb_rv_elastic_reg.sv
// Randomised and directed bench for rv_elastic_reg; a negedge monitor checks every cycle
// against a queue-based reference model of the buffer contents.
module tb_rv_elastic_reg;
  localparam int               WIDTH = 3;
  localparam int               DEPTH = 4;
  localparam logic [WIDTH-1:0] RV    = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] exp_q [$];

  rv_elastic_reg_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  rv_elastic_reg #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are applied now and held across the next rising edge; returns 1 unit after it.
  task automatic cyc(input bit iv, input logic [WIDTH-1:0] d, input bit ordy, input bit c);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clr           = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue holding exactly the words the buffer should contain.
  always @(negedge clk) begin : monitor
    int n;
    if (!rst) exp_q.delete();
    n = exp_q.size();
    check("mon_count", 32'(bus.count), n);
    check("mon_empty", bus.empty, n == 0);
    check("mon_full", bus.full, n == DEPTH);
    check("mon_in_ready", bus.in_ready, n != DEPTH);
    check("mon_out_valid", bus.out_valid, n != 0);
    check("mon_out_data", bus.out_data, (n != 0) ? exp_q[0] : RV);
    if (rst) begin
      if (clr) begin
        exp_q.delete();
        $display("[TB] clear, %0d words dropped", n);
      end else begin
        if (n > 0 && bus.out_ready) begin
          $display("[TB] pop  data=%0d", exp_q[0]);
          void'(exp_q.pop_front());
        end
        if (bus.in_valid && n < DEPTH) begin
          $display("[TB] push data=%0d", bus.in_data);
          exp_q.push_back(bus.in_data);
        end
      end
    end
  end

  initial begin
    int din [6];
    int pre [6];
    din = '{5, 6, 7, 0, 1, 2};
    pre = '{3, 4, 5, 6, 7, 0};
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    #2;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, RV);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_count", 32'(bus.count), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill to full with the consumer stalled, then drain on consecutive cycles.
    for (int i = 1; i <= 4; i++) cyc(1'b1, WIDTH'(i), 1'b0, 1'b0);
    check("fill_count", 32'(bus.count), 4);
    check("fill_full", bus.full, 1);
    check("fill_in_ready", bus.in_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", bus.out_data, i);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    check("drain_empty", bus.empty, 1);

    // Popping an empty buffer changes nothing.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 3'd3, 1'b1, 1'b0);
      check("empty_pop_count", 32'(bus.count), 0);
      check("empty_pop_data", bus.out_data, RV);
    end

    // Simultaneous push and pop at count 2 with pointer wrap.
    cyc(1'b1, 3'd3, 1'b0, 1'b0);
    cyc(1'b1, 3'd4, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      check("pp_out_data", bus.out_data, pre[k]);
      cyc(1'b1, WIDTH'(din[k]), 1'b1, 1'b0);
      check("pp_count", 32'(bus.count), 2);
    end
    check("pp_tail_data", bus.out_data, 1);

    // Full buffer refuses a push even while being popped; accepted one edge later.
    cyc(1'b1, 3'd3, 1'b0, 1'b0);
    cyc(1'b1, 3'd4, 1'b0, 1'b0);
    check("full_flag", bus.full, 1);
    cyc(1'b1, 3'd7, 1'b1, 1'b0);
    check("full_refuse_count", 32'(bus.count), 3);
    check("full_refuse_data", bus.out_data, 2);
    cyc(1'b1, 3'd7, 1'b0, 1'b0);
    check("full_accept_count", 32'(bus.count), 4);

    // Flush at count 3 overrides concurrent push and pop.
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("pre_clr_count", 32'(bus.count), 3);
    cyc(1'b1, 3'd6, 1'b1, 1'b1);
    check("clr_count", 32'(bus.count), 0);
    check("clr_out_valid", bus.out_valid, 0);
    check("clr_out_data", bus.out_data, RV);
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("clr_push_dropped", 32'(bus.count), 0);

    // Asynchronous reset between edges while holding two words.
    cyc(1'b1, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 32'(bus.count), 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_data", bus.out_data, RV);
    check("arst_empty", bus.empty, 1);
    check("arst_full", bus.full, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b1, 3'd6, 1'b0, 1'b0);
    check("arst_push_data", bus.out_data, 6);
    check("arst_push_valid", bus.out_valid, 1);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Random traffic, occasional flush; in_data toggles freely on non-push cycles.
    repeat (400) begin
      cyc(1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
    end
    repeat (DEPTH + 2) cyc(1'b0, '0, 1'b1, 1'b0);
    check("final_count", 32'(bus.count), 0);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
